// File: rtl/pong_if.sv
// Control inputs and game-state outputs exchanged between the Pong physics engine
// and its keypad/game-FSM/graphics neighbours.
interface pong_if;
  logic       tick;
  logic       stop;
  logic       serve;
  logic       up1;
  logic       down1;
  logic       up2;
  logic       down2;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] paddle1_y;
  logic [9:0] paddle2_y;
  logic       miss1;
  logic       miss2;
  logic       hit;
  logic [2:0] speed;

  modport master (
    output tick, stop, serve, up1, down1, up2, down2,
    input  ball_x, ball_y, paddle1_y, paddle2_y, miss1, miss2, hit, speed
  );

  modport slave (
    input  tick, stop, serve, up1, down1, up2, down2,
    output ball_x, ball_y, paddle1_y, paddle2_y, miss1, miss2, hit, speed
  );
endinterface

// File: rtl/pong_physics_engine.sv
// Pong game physics: advances ball and paddles once per game-step strobe,
// reports paddle deflections and misses, and ramps ball speed with rally length.
module pong_physics_engine #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_H       = 64,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE1_X      = 16,
  parameter int PADDLE2_X      = 616,
  parameter int PADDLE_STEP    = 4,
  parameter int BALL_STEP_INIT = 2,
  parameter int BALL_STEP_MAX  = 6,
  parameter int HITS_PER_LEVEL = 4
) (
  input  logic clk,
  input  logic rst,
  pong_if.slave bus
);

  localparam logic [1:0] ST_SERVE  = 2'd0;
  localparam logic [1:0] ST_MOVE   = 2'd1;
  localparam logic [1:0] ST_MISSED = 2'd2;

  localparam logic [9:0]  BALL_X0  = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  BALL_Y0  = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0]  PAD_Y0   = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [10:0] Y_MAX    = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] X_MAX    = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] PAD_MAX  = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] X_HIT2   = 11'(PADDLE2_X - BALL_SIZE);
  localparam logic [10:0] X_HIT1   = 11'(PADDLE1_X + PADDLE_W);
  localparam logic [10:0] P_STEP   = 11'(PADDLE_STEP);
  localparam logic [10:0] B_SZ     = 11'(BALL_SIZE);
  localparam logic [10:0] P_H      = 11'(PADDLE_H);
  localparam logic [2:0]  SPD_INIT = 3'(BALL_STEP_INIT);
  localparam logic [2:0]  SPD_MAX  = 3'(BALL_STEP_MAX);
  localparam logic [2:0]  HIT_LAST = 3'(HITS_PER_LEVEL - 1);

  logic [1:0] state_q, state_d;
  logic [9:0] ball_x_q, ball_x_d;
  logic [9:0] ball_y_q, ball_y_d;
  logic [9:0] paddle1_y_q, paddle1_y_d;
  logic [9:0] paddle2_y_q, paddle2_y_d;
  logic       dir_x_q, dir_x_d;   // 1 = moving right
  logic       dir_y_q, dir_y_d;   // 1 = moving down
  logic [2:0] speed_q, speed_d;
  logic [2:0] hit_cnt_q, hit_cnt_d;
  logic       miss1_q, miss1_d;
  logic       miss2_q, miss2_d;
  logic       hit_q, hit_d;

  logic        step;
  logic [10:0] bx, by, sp, nx, ny;

  // Up/down request applied with clamping to the playfield; both or neither holds.
  function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up,
                                             input logic dn);
    logic [10:0] y_w;
    y_w = {1'b0, y};
    if (up && !dn) begin
      y_w = (y_w <= P_STEP) ? 11'd0 : y_w - P_STEP;
    end else if (dn && !up) begin
      y_w = (y_w + P_STEP >= PAD_MAX) ? PAD_MAX : y_w + P_STEP;
    end
    return 10'(y_w);
  endfunction

  function automatic logic overlap(input logic [10:0] ball_top, input logic [9:0] pad_top);
    logic [10:0] p;
    p = {1'b0, pad_top};
    return (ball_top + B_SZ > p) && (ball_top < p + P_H);
  endfunction

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    paddle1_y_d = paddle1_y_q;
    paddle2_y_d = paddle2_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    speed_d     = speed_q;
    hit_cnt_d   = hit_cnt_q;
    miss1_d     = 1'b0;
    miss2_d     = 1'b0;
    hit_d       = 1'b0;
    step        = bus.tick && !bus.stop;
    bx          = {1'b0, ball_x_q};
    by          = {1'b0, ball_y_q};
    sp          = {8'd0, speed_q};
    nx          = bx;
    ny          = by;

    case (state_q)
      ST_SERVE: begin
        if (step) begin
          paddle1_y_d = paddle_next(paddle1_y_q, bus.up1, bus.down1);
          paddle2_y_d = paddle_next(paddle2_y_q, bus.up2, bus.down2);
          state_d     = ST_MOVE;
        end
      end

      ST_MOVE: begin
        if (step) begin
          paddle1_y_d = paddle_next(paddle1_y_q, bus.up1, bus.down1);
          paddle2_y_d = paddle_next(paddle2_y_q, bus.up2, bus.down2);

          if (dir_y_q) begin
            if (by + sp >= Y_MAX) begin
              ny      = Y_MAX;
              dir_y_d = 1'b0;
            end else begin
              ny = by + sp;
            end
          end else begin
            if (by <= sp) begin
              ny      = 11'd0;
              dir_y_d = 1'b1;
            end else begin
              ny = by - sp;
            end
          end

          // Overlap uses the pre-step ball and paddle positions; deflection beats miss.
          if (dir_x_q) begin
            if (bx < X_HIT2 && bx + sp >= X_HIT2 && overlap(by, paddle2_y_q)) begin
              nx      = X_HIT2;
              dir_x_d = 1'b0;
              hit_d   = 1'b1;
            end else if (bx + sp >= X_MAX) begin
              nx      = X_MAX;
              miss2_d = 1'b1;
              state_d = ST_MISSED;
            end else begin
              nx = bx + sp;
            end
          end else begin
            if (bx > X_HIT1 && bx <= X_HIT1 + sp && overlap(by, paddle1_y_q)) begin
              nx      = X_HIT1;
              dir_x_d = 1'b1;
              hit_d   = 1'b1;
            end else if (bx <= sp) begin
              nx      = 11'd0;
              miss1_d = 1'b1;
              state_d = ST_MISSED;
            end else begin
              nx = bx - sp;
            end
          end

          ball_x_d = 10'(nx);
          ball_y_d = 10'(ny);

          if (hit_d) begin
            if (hit_cnt_q == HIT_LAST) begin
              hit_cnt_d = 3'd0;
              if (speed_q < SPD_MAX) speed_d = 3'(speed_q + 3'd1);
            end else begin
              hit_cnt_d = 3'(hit_cnt_q + 3'd1);
            end
          end
        end
      end

      ST_MISSED: begin
        // dir_x is left as-is: it already points at the player who missed.
        if (bus.serve) begin
          ball_x_d  = BALL_X0;
          ball_y_d  = BALL_Y0;
          speed_d   = SPD_INIT;
          hit_cnt_d = 3'd0;
          state_d   = ST_SERVE;
        end
      end

      default: state_d = ST_SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SERVE;
      ball_x_q    <= BALL_X0;
      ball_y_q    <= BALL_Y0;
      paddle1_y_q <= PAD_Y0;
      paddle2_y_q <= PAD_Y0;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      speed_q     <= SPD_INIT;
      hit_cnt_q   <= 3'd0;
      miss1_q     <= 1'b0;
      miss2_q     <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      paddle1_y_q <= paddle1_y_d;
      paddle2_y_q <= paddle2_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      speed_q     <= speed_d;
      hit_cnt_q   <= hit_cnt_d;
      miss1_q     <= miss1_d;
      miss2_q     <= miss2_d;
      hit_q       <= hit_d;
    end
  end

  assign bus.ball_x    = ball_x_q;
  assign bus.ball_y    = ball_y_q;
  assign bus.paddle1_y = paddle1_y_q;
  assign bus.paddle2_y = paddle2_y_q;
  assign bus.miss1     = miss1_q;
  assign bus.miss2     = miss2_q;
  assign bus.hit       = hit_q;
  assign bus.speed     = speed_q;

endmodule

// File: tb/tb_pong_physics_engine.sv
// Bench for pong_physics_engine: vector table, directed game scenarios, a steered
// rally and random play, all checked against an arithmetic model of the game rules.
module tb_pong_physics_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pong_if bus();

  pong_physics_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum int {M_SERVE, M_MOVE, M_MISSED} mst_t;
  typedef struct {
    int   x, y, p1, p2, dx, dy, spd, hits;
    mst_t st;
    bit   m1, m2, h;
  } m_t;

  typedef struct {
    bit t, s, u1, d1, u2, d2;
    int bx, by, p1, p2;
  } vec_t;

  m_t m;
  int ntest = 0;
  int nfail = 0;

  function automatic m_t mreset();
    m_t s;
    s.x = 316; s.y = 236; s.p1 = 208; s.p2 = 208;
    s.dx = 1; s.dy = 1; s.spd = 2; s.hits = 0;
    s.st = M_SERVE; s.m1 = 0; s.m2 = 0; s.h = 0;
    return s;
  endfunction

  function automatic int pad(int y, bit u, bit d);
    if (u && !d) return (y - 4 < 0) ? 0 : y - 4;
    if (d && !u) return (y + 4 > 416) ? 416 : y + 4;
    return y;
  endfunction

  function automatic m_t mstep(m_t s, bit r, bit t, bit st, bit sv,
                               bit u1, bit d1, bit u2, bit d2);
    m_t n;
    int nx, ny;
    bit ov1, ov2;
    n = s;
    n.m1 = 0; n.m2 = 0; n.h = 0;
    if (r) return mreset();
    if (s.st == M_MISSED) begin
      if (sv) begin
        n.x = 316; n.y = 236; n.spd = 2; n.hits = 0; n.st = M_SERVE;
      end
      return n;
    end
    if (!(t && !st)) return n;
    n.p1 = pad(s.p1, u1, d1);
    n.p2 = pad(s.p2, u2, d2);
    if (s.st == M_SERVE) begin
      n.st = M_MOVE;
      return n;
    end
    ny = s.y + s.dy * s.spd;
    if (ny >= 472) begin ny = 472; n.dy = -1; end
    else if (ny <= 0) begin ny = 0; n.dy = 1; end
    n.y = ny;
    ov1 = (s.y + 8 > s.p1) && (s.y < s.p1 + 64);
    ov2 = (s.y + 8 > s.p2) && (s.y < s.p2 + 64);
    nx = s.x + s.dx * s.spd;
    if (s.dx > 0) begin
      if (s.x < 608 && nx >= 608 && ov2) begin nx = 608; n.dx = -1; n.h = 1; end
      else if (nx >= 632) begin nx = 632; n.m2 = 1; n.st = M_MISSED; end
    end else begin
      if (s.x > 24 && nx <= 24 && ov1) begin nx = 24; n.dx = 1; n.h = 1; end
      else if (nx <= 0) begin nx = 0; n.m1 = 1; n.st = M_MISSED; end
    end
    n.x = nx;
    if (n.h) begin
      n.hits = s.hits + 1;
      if (n.hits == 4) begin
        n.hits = 0;
        n.spd = (s.spd + 1 > 6) ? 6 : s.spd + 1;
      end
    end
    return n;
  endfunction

  // Ball y at the step where it reaches the paddle plane it is heading for.
  function automatic int predict(m_t s);
    for (int i = 0; i < 2000; i++) begin
      if (s.st != M_MOVE) return 236;
      if (s.dx > 0 && s.x + s.spd >= 608) return s.y;
      if (s.dx < 0 && s.x - s.spd <= 24) return s.y;
      s = mstep(s, 0, 1, 0, 0, 0, 0, 0, 0);
    end
    return 236;
  endfunction

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    ntest++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model();
    ntest++;
    if (bus.ball_x !== 10'(m.x) || bus.ball_y !== 10'(m.y) ||
        bus.paddle1_y !== 10'(m.p1) || bus.paddle2_y !== 10'(m.p2) ||
        bus.speed !== 3'(m.spd) || bus.miss1 !== m.m1 || bus.miss2 !== m.m2 ||
        bus.hit !== m.h) begin
      nfail++;
      $display("FAIL model @%0t: got x=%0d y=%0d p1=%0d p2=%0d spd=%0d m1=%b m2=%b h=%b expected x=%0d y=%0d p1=%0d p2=%0d spd=%0d m1=%b m2=%b h=%b",
               $time, bus.ball_x, bus.ball_y, bus.paddle1_y, bus.paddle2_y, bus.speed,
               bus.miss1, bus.miss2, bus.hit, m.x, m.y, m.p1, m.p2, m.spd, m.m1, m.m2, m.h);
    end
  endtask

  task automatic cyc(input bit r, input bit t, input bit s, input bit sv,
                     input bit u1, input bit d1, input bit u2, input bit d2);
    @(negedge clk);
    rst = r; bus.tick = t; bus.stop = s; bus.serve = sv;
    bus.up1 = u1; bus.down1 = d1; bus.up2 = u2; bus.down2 = d2;
    @(posedge clk);
    m = mstep(m, r, t, s, sv, u1, d1, u2, d2);
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic stepk(input bit u1, input bit d1, input bit u2, input bit d2);
    cyc(0, 1, 0, 0, u1, d1, u2, d2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   hits, cycles, t1, t2;
    bit   k1u, k1d, k2u, k2d;

    bus.tick = 0; bus.stop = 0; bus.serve = 0;
    bus.up1 = 0; bus.down1 = 0; bus.up2 = 0; bus.down2 = 0;
    m = mreset();

    tbl[0] = '{1, 1, 1, 0, 0, 0, 316, 236, 208, 208};
    tbl[1] = '{0, 0, 1, 0, 0, 0, 316, 236, 208, 208};
    tbl[2] = '{1, 0, 1, 0, 0, 0, 316, 236, 204, 208};
    tbl[3] = '{1, 0, 0, 0, 0, 1, 318, 238, 204, 212};
    tbl[4] = '{1, 0, 0, 0, 1, 1, 320, 240, 204, 212};
    tbl[5] = '{1, 0, 0, 1, 0, 0, 322, 242, 208, 212};
    tbl[6] = '{0, 0, 1, 0, 0, 0, 322, 242, 208, 212};
    tbl[7] = '{1, 1, 0, 1, 0, 0, 322, 242, 208, 212};

    // Reset state
    do_reset();
    chk("rst_ball_x", bus.ball_x, 316);
    chk("rst_ball_y", bus.ball_y, 236);
    chk("rst_paddle1", bus.paddle1_y, 208);
    chk("rst_paddle2", bus.paddle2_y, 208);
    chk("rst_speed", bus.speed, 2);
    chk("rst_pulses", {bus.miss1, bus.miss2, bus.hit}, 0);

    for (int i = 0; i < 8; i++) begin
      cyc(0, tbl[i].t, tbl[i].s, 0, tbl[i].u1, tbl[i].d1, tbl[i].u2, tbl[i].d2);
      chk($sformatf("vec%0d_ball_x", i), bus.ball_x, tbl[i].bx);
      chk($sformatf("vec%0d_ball_y", i), bus.ball_y, tbl[i].by);
      chk($sformatf("vec%0d_paddle1", i), bus.paddle1_y, tbl[i].p1);
      chk($sformatf("vec%0d_paddle2", i), bus.paddle2_y, tbl[i].p2);
      chk($sformatf("vec%0d_pulses", i), {bus.miss1, bus.miss2, bus.hit}, 0);
    end

    // Wall bounce, then a miss at the right side and re-serve
    do_reset();
    stepk(0, 0, 0, 0);
    for (int i = 0; i < 118; i++) stepk(0, 0, 0, 0);
    chk("wall_ball_y", bus.ball_y, 472);
    chk("wall_ball_x", bus.ball_x, 552);
    stepk(0, 0, 0, 0);
    chk("wall_bounce_y", bus.ball_y, 470);
    for (int i = 0; i < 38; i++) stepk(0, 0, 0, 0);
    stepk(0, 0, 0, 0);
    chk("miss_ball_x", bus.ball_x, 632);
    chk("miss_ball_y", bus.ball_y, 392);
    chk("miss2_pulse", bus.miss2, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("miss2_clear", bus.miss2, 0);
    for (int i = 0; i < 3; i++) stepk(1, 0, 0, 1);
    chk("missed_frozen_x", bus.ball_x, 632);
    chk("missed_frozen_p1", bus.paddle1_y, 208);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    chk("serve_ball_x", bus.ball_x, 316);
    chk("serve_ball_y", bus.ball_y, 236);
    chk("serve_speed", bus.speed, 2);
    stepk(0, 0, 0, 0);
    stepk(0, 0, 0, 0);
    chk("serve_dir_right", bus.ball_x, 318);

    // Paddle 2 deflection
    do_reset();
    for (int i = 0; i < 52; i++) stepk(0, 0, 0, 1);
    chk("p2_clamp_bottom", bus.paddle2_y, 416);
    for (int i = 0; i < 94; i++) stepk(0, 0, 0, 1);
    stepk(0, 0, 0, 1);
    chk("hit_ball_x", bus.ball_x, 608);
    chk("hit_pulse", bus.hit, 1);
    chk("hit_speed", bus.speed, 2);
    stepk(0, 0, 0, 1);
    chk("hit_dir_left", bus.ball_x, 606);
    chk("hit_clear", bus.hit, 0);

    // Paddle clamp at top and conflicting requests
    do_reset();
    for (int i = 0; i < 60; i++) stepk(1, 0, 0, 0);
    chk("p1_clamp_top", bus.paddle1_y, 0);
    for (int i = 0; i < 5; i++) stepk(0, 0, 1, 1);
    chk("p2_conflict_hold", bus.paddle2_y, 208);

    // Steered rally: speed ramps with hits and saturates
    do_reset();
    hits = 0;
    cycles = 0;
    while (hits < 20 && cycles < 20000 && m.st != M_MISSED) begin
      t1 = (m.st == M_MOVE && m.dx < 0) ? clampi(predict(m) - 28, 0, 416) : 208;
      t2 = (m.st == M_MOVE && m.dx > 0) ? clampi(predict(m) - 28, 0, 416) : 208;
      k1u = m.p1 > t1 + 2; k1d = m.p1 < t1 - 2;
      k2u = m.p2 > t2 + 2; k2d = m.p2 < t2 - 2;
      stepk(k1u, k1d, k2u, k2d);
      cycles++;
      if (m.h) begin
        hits++;
        if (hits == 4)  chk("speed_after_4_hits", bus.speed, 3);
        if (hits == 8)  chk("speed_after_8_hits", bus.speed, 4);
        if (hits == 16) chk("speed_after_16_hits", bus.speed, 6);
      end
    end
    chk("rally_hits", hits, 20);
    chk("speed_saturated", bus.speed, 6);

    // Random play against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 999) == 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/pong_physics_engine.md
Name: pong_physics_engine

Overview:
Game-physics stage of the Pong datapath. Owns ball position/direction/speed and both paddle positions, advancing them once per game-step strobe from debounced keypad controls. Emits miss pulses to the game/score FSM, and coordinates to the graphics generator.

Parameters:
SCREEN_W, 640, playfield width in pixels
SCREEN_H, 480, playfield height in pixels
BALL_SIZE, 8, ball edge length in pixels (square)
PADDLE_H, 64, paddle height in pixels
PADDLE_W, 8, paddle width in pixels
PADDLE1_X, 16, left edge x of paddle 1
PADDLE2_X, 616, left edge x of paddle 2
PADDLE_STEP, 4, paddle pixels moved per tick
BALL_STEP_INIT, 2, ball pixels per tick on serve (both axes)
BALL_STEP_MAX, 6, speed saturation value
HITS_PER_LEVEL, 4, paddle hits per speed increment

Ports:
clk  in  1  system clock
rst  in  1  reset
tick  in  1  one-cycle game-step strobe
stop  in  1  high = freeze all motion (game not in play)
serve  in  1  one-cycle pulse: re-serve after a miss
up1  in  1  paddle 1 up request (level)
down1  in  1  paddle 1 down request (level)
up2  in  1  paddle 2 up request (level)
down2  in  1  paddle 2 down request (level)
ball_x  out  10  ball left edge x
ball_y  out  10  ball top edge y
paddle1_y  out  10  paddle 1 top edge y
paddle2_y  out  10  paddle 2 top edge y
miss1  out  1  one-cycle pulse: ball passed paddle 1
miss2  out  1  one-cycle pulse: ball passed paddle 2
hit  out  1  one-cycle pulse: paddle deflection
speed  out  3  current ball step

Behaviour:
- One clock; reset is synchronous and active-high: rst sampled on posedge clk, overrides all other inputs.
- Reset values: ball_x=316, ball_y=236 (centred), paddle1_y=paddle2_y=208, dir_x=+ (right), dir_y=+ (down), speed=BALL_STEP_INIT, hit counter=0, miss1=miss2=hit=0, state=SERVE.
- All outputs registered; an update caused by tick at edge N is visible after edge N. miss1/miss2/hit are high exactly one cycle, deasserted otherwise.
- "Step" = tick=1 and stop=0. Nothing changes on tick with stop=1 or on cycles without tick.
- Paddles (step, state SERVE or MOVE): up only: y=max(y-PADDLE_STEP,0). Down only: y=min(y+PADDLE_STEP,SCREEN_H-PADDLE_H). Both or neither: hold. Paddles frozen in MISSED.
- States:
  - SERVE: ball held at centre. On step -> MOVE; ball does not move on that step.
  - MOVE: ball advances on each step (below).
  - MISSED: ball frozen at final position. serve=1 -> ball recentred, speed=BALL_STEP_INIT, hit counter=0, dir_x toward the player who missed, dir_y kept -> SERVE. serve is ignored in SERVE and MOVE.
- Ball y (MOVE step): down and y+speed>=SCREEN_H-BALL_SIZE: y=472, dir up. Up and y<=speed: y=0, dir down. Else y±speed.
- Ball x (MOVE step, uses pre-step ball_y and paddle_y for overlap; overlap = ball_y+BALL_SIZE>paddle_y and ball_y<paddle_y+PADDLE_H):
  - Right: x<608 and x+speed>=608 with paddle 2 overlap -> x=608, dir left, hit. Else x+speed>=632 -> x=632, miss2, ->MISSED. Else x+=speed.
  - Left: x>24 and x-speed<=24 with paddle 1 overlap -> x=24, dir right, hit. Else x<=speed -> x=0, miss1, ->MISSED. Else x-=speed.
  - Hit check has priority over miss; y update applies on the same step as hit or miss.
- Speed: each hit increments the hit counter. On reaching HITS_PER_LEVEL, counter clears and speed=min(speed+1,BALL_STEP_MAX).
- All arithmetic 11-bit internally; no wrap of 10-bit coordinates.
- rst during MOVE or MISSED: full reset values next cycle; pending pulses dropped.

Test Plan:
- Reset: assert rst 2 cycles -> ball (316,236), paddles 208/208, speed=2, all pulses 0; ticks with stop=1 change nothing.
- Wall bounce: release, 1 step (SERVE->MOVE), then 118 steps -> ball_y=472, ball_x=552; next step -> ball_y=470.
- Miss: no keys, continue stepping -> ball_x reaches 632 after step 158 of MOVE with ball_y=392 and miss2 high one cycle. Further ticks freeze; serve -> ball (316,236), speed 2, dir right.
- Hit: hold down2 from reset -> paddle2_y saturates at 416 after 52 steps. At MOVE step 146 ball_x=608, hit pulse, dir left; speed stays 2.
- Speed-up: rally 4 hits (bench steers paddles) -> speed=3 after 4th hit. Continue to 16 hits -> speed saturates at 6.
- Paddle clamp/conflict: up1 held 60 steps -> paddle1_y=0 and holds. up2+down2 together -> paddle2_y unchanged.
